// File: rtl/spatz_pkg.sv
// Shared Spatz types.
// Holds the VRF word/address/byte-enable types, the VFU completion response,
// and the write-back buffer entry that the VFU builds for each result word.
package spatz_pkg;

    localparam int unsigned VfuWbDepth = 2;

    typedef logic [9:0]  vreg_addr_t;
    typedef logic [63:0] vreg_data_t;
    typedef logic [7:0]  vreg_be_t;

    typedef struct packed {
        logic [2:0] id;
        logic [4:0] vs2;
        logic [4:0] vs1;
        logic [4:0] vd;
    } vfu_rsp_t;

    // One buffered result word; we=0 marks a response-only entry.
    typedef struct packed {
        logic       we;
        vreg_addr_t waddr;
        vreg_data_t wdata;
        vreg_be_t   wbe;
        logic       last;
        vfu_rsp_t   rsp;
    } vfu_wb_entry_t;

endpackage

// File: rtl/spatz_vfu_wb_buffer.sv
// VFU write-back buffer.
// Decouples the VFU result path from the VRF write port with a small circular
// FIFO. The completion response for an instruction is issued one cycle after
// its last word leaves the buffer (VRF-acknowledged, or drained if response-only).
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   res_*_i / res_ready_o  result word from the VFU (valid/ready)
//   vrf_*_o / vrf_wvalid_i head entry write request and VRF acknowledge
//   vfu_rsp_valid_o/_o     registered one-cycle completion response
//   empty_o                nothing pending, including an unissued response
module spatz_vfu_wb_buffer
    import spatz_pkg::*;
#(
    parameter int unsigned Depth = VfuWbDepth
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       res_valid_i,
    output logic       res_ready_o,
    input  logic       res_we_i,
    input  vreg_addr_t res_waddr_i,
    input  vreg_data_t res_wdata_i,
    input  vreg_be_t   res_wbe_i,
    input  logic       res_last_i,
    input  vfu_rsp_t   res_rsp_i,
    output logic       vrf_we_o,
    output vreg_addr_t vrf_waddr_o,
    output vreg_data_t vrf_wdata_o,
    output vreg_be_t   vrf_wbe_o,
    input  logic       vrf_wvalid_i,
    output logic       vfu_rsp_valid_o,
    output vfu_rsp_t   vfu_rsp_o,
    output logic       empty_o
);

    localparam int unsigned CntWidth = $clog2(Depth + 1);
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);
    localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 1);

    vfu_wb_entry_t         entry_q [Depth];
    logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]   count_q, count_d;
    logic                  rsp_valid_q, rsp_valid_d;
    vfu_rsp_t              rsp_q, rsp_d;

    vfu_wb_entry_t head;
    vfu_wb_entry_t new_entry;
    logic          push, pop, not_empty;

    always_comb begin
        head      = entry_q[rd_ptr_q];
        not_empty = (count_q != '0);
        // Response-only heads drain without waiting for the VRF.
        pop       = not_empty && (!head.we || vrf_wvalid_i);
        // A full buffer still accepts when the head leaves this cycle.
        res_ready_o = (count_q < DepthCnt) || pop;
        push      = res_valid_i && res_ready_o;

        new_entry       = '0;
        new_entry.we    = res_we_i;
        new_entry.waddr = res_waddr_i;
        new_entry.wdata = res_wdata_i;
        new_entry.wbe   = res_wbe_i;
        new_entry.last  = res_last_i;
        new_entry.rsp   = res_rsp_i;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;

        rsp_valid_d = pop && head.last;
        rsp_d       = (pop && head.last) ? head.rsp : rsp_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) entry_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            if (push) entry_q[wr_ptr_q] <= new_entry;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    assign vrf_we_o        = not_empty && head.we;
    assign vrf_waddr_o     = head.waddr;
    assign vrf_wdata_o     = head.wdata;
    assign vrf_wbe_o       = head.wbe;
    assign vfu_rsp_valid_o = rsp_valid_q;
    assign vfu_rsp_o       = rsp_q;
    assign empty_o         = !not_empty && !rsp_valid_q;

endmodule

// File: tb/tb_spatz_vfu_wb_buffer.sv
module tb_spatz_vfu_wb_buffer;
    import spatz_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       res_valid_i = 1'b0;
    logic       res_ready_o;
    logic       res_we_i = 1'b0;
    vreg_addr_t res_waddr_i = '0;
    vreg_data_t res_wdata_i = '0;
    vreg_be_t   res_wbe_i = '0;
    logic       res_last_i = 1'b0;
    vfu_rsp_t   res_rsp_i = '0;
    logic       vrf_we_o;
    vreg_addr_t vrf_waddr_o;
    vreg_data_t vrf_wdata_o;
    vreg_be_t   vrf_wbe_o;
    logic       vrf_wvalid_i = 1'b0;
    logic       vfu_rsp_valid_o;
    vfu_rsp_t   vfu_rsp_o;
    logic       empty_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit toggle_en = 1'b0;

    vfu_wb_entry_t model_q[$];
    logic          exp_rv = 1'b0;
    vfu_rsp_t      exp_r  = '0;

    spatz_vfu_wb_buffer #(.Depth(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
        .res_we_i(res_we_i), .res_waddr_i(res_waddr_i), .res_wdata_i(res_wdata_i),
        .res_wbe_i(res_wbe_i), .res_last_i(res_last_i), .res_rsp_i(res_rsp_i),
        .vrf_we_o(vrf_we_o), .vrf_waddr_o(vrf_waddr_o), .vrf_wdata_o(vrf_wdata_o),
        .vrf_wbe_o(vrf_wbe_o), .vrf_wvalid_i(vrf_wvalid_i),
        .vfu_rsp_valid_o(vfu_rsp_valid_o), .vfu_rsp_o(vfu_rsp_o), .empty_o(empty_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (toggle_en) vrf_wvalid_i = !vrf_wvalid_i;
    endtask

    // Holds the word on the input until accepted; returns just after the accepting edge.
    task automatic push_word(input logic we, input vreg_addr_t a, input vreg_data_t d,
                             input logic last, input logic [2:0] id);
        bit acc;
        acc = 1'b0;
        res_valid_i = 1'b1;
        res_we_i    = we;
        res_waddr_i = a;
        res_wdata_i = d;
        res_wbe_i   = 8'hA5 ^ a[7:0];
        res_last_i  = last;
        res_rsp_i   = '{id: id, vs2: 5'(a), vs1: 5'(id), vd: 5'(a + 1)};
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            acc = res_ready_o;
            step();
        end
        res_valid_i = 1'b0;
        chk("push_accept_timeout", {127'd0, acc}, 128'd1);
    endtask

    task automatic wait_empty(input int n);
        bit done;
        done = 1'b0;
        for (int i = 0; i < n && !done; i++) begin
            @(negedge clk);
            if (empty_o) done = 1'b1;
            else step();
        end
        chk("drain_timeout", {127'd0, done}, 128'd1);
        step();
    endtask

    // Scoreboard: reference FIFO of expected entries, checked every cycle.
    always @(negedge clk) begin
        vfu_wb_entry_t h;
        vfu_wb_entry_t e;
        logic          mpop;
        logic          nxt_v;
        vfu_rsp_t      nxt_r;
        int            sz;
        if (!rst_n) begin
            model_q.delete();
            exp_rv = 1'b0;
            exp_r  = '0;
            chk("rst_vrf_we", 128'(vrf_we_o), 128'd0);
            chk("rst_rsp_valid", 128'(vfu_rsp_valid_o), 128'd0);
            chk("rst_rsp", 128'(vfu_rsp_o), 128'd0);
            chk("rst_empty", 128'(empty_o), 128'd1);
            chk("rst_ready", 128'(res_ready_o), 128'd1);
        end else begin
            chk("rsp_valid", 128'(vfu_rsp_valid_o), 128'(exp_rv));
            chk("rsp_value", 128'(vfu_rsp_o), 128'(exp_r));
            sz = model_q.size();
            chk("empty", 128'(empty_o), 128'((sz == 0) && !exp_rv));
            mpop  = 1'b0;
            nxt_v = 1'b0;
            nxt_r = exp_r;
            if (sz == 0) begin
                chk("vrf_we_idle", 128'(vrf_we_o), 128'd0);
            end else begin
                h = model_q[0];
                if (h.we) begin
                    chk("vrf_we", 128'(vrf_we_o), 128'd1);
                    chk("vrf_waddr", 128'(vrf_waddr_o), 128'(h.waddr));
                    chk("vrf_wdata", 128'(vrf_wdata_o), 128'(h.wdata));
                    chk("vrf_wbe", 128'(vrf_wbe_o), 128'(h.wbe));
                    mpop = vrf_wvalid_i;
                end else begin
                    chk("vrf_we_rsp_only", 128'(vrf_we_o), 128'd0);
                    mpop = 1'b1;
                end
                if (mpop) begin
                    void'(model_q.pop_front());
                    if (h.last) begin
                        nxt_v = 1'b1;
                        nxt_r = h.rsp;
                    end
                end
            end
            chk("res_ready", 128'(res_ready_o), 128'((sz < DEPTH) || mpop));
            if (res_valid_i && res_ready_o) begin
                e.we    = res_we_i;
                e.waddr = res_waddr_i;
                e.wdata = res_wdata_i;
                e.wbe   = res_wbe_i;
                e.last  = res_last_i;
                e.rsp   = res_rsp_i;
                model_q.push_back(e);
            end
            exp_rv = nxt_v;
            exp_r  = nxt_r;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #23 rst_n = 1'b1;
        step();

        // Single word, VRF always ready.
        vrf_wvalid_i = 1'b1;
        push_word(1'b1, 10'h010, 64'h1111_2222_3333_4444, 1'b1, 3'd3);
        chk("single_we_c1", 128'(vrf_we_o), 128'd1);
        chk("single_addr_c1", 128'(vrf_waddr_o), 128'h10);
        step();
        chk("single_rsp_valid_c2", 128'(vfu_rsp_valid_o), 128'd1);
        chk("single_rsp_id_c2", 128'(vfu_rsp_o.id), 128'd3);
        step();
        chk("single_empty_c3", 128'(empty_o), 128'd1);

        // Backpressure: fill to Depth, third word waits.
        vrf_wvalid_i = 1'b0;
        push_word(1'b1, 10'h020, 64'hA0A0_0000_0000_0001, 1'b0, 3'd4);
        push_word(1'b1, 10'h021, 64'hA1A1_0000_0000_0002, 1'b0, 3'd4);
        res_valid_i = 1'b1;
        res_waddr_i = 10'h022;
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready_low", 128'(res_ready_o), 128'd0);
            chk("bp_head_stable", 128'(vrf_waddr_o), 128'h20);
            step();
        end
        // Full buffer: push lands in the same cycle as the pop.
        vrf_wvalid_i = 1'b1;
        push_word(1'b1, 10'h022, 64'hA2A2_0000_0000_0003, 1'b1, 3'd4);
        chk("full_simul_not_empty", 128'(empty_o), 128'd0);
        wait_empty(20);

        // Response-only entry.
        vrf_wvalid_i = 1'b0;
        push_word(1'b0, 10'h3FF, 64'hDEAD, 1'b1, 3'd5);
        step();
        chk("rsp_only_valid", 128'(vfu_rsp_valid_o), 128'd1);
        chk("rsp_only_id", 128'(vfu_rsp_o.id), 128'd5);
        wait_empty(10);

        // Mixed instructions with a toggling VRF acknowledge.
        toggle_en = 1'b1;
        for (int i = 0; i < 4; i++)
            push_word(1'b1, 10'(10'h040 + i), {32'(i), $urandom}, (i == 3), 3'd1);
        for (int i = 0; i < 2; i++)
            push_word(1'b1, 10'(10'h080 + i), {32'(i + 16), $urandom}, (i == 1), 3'd2);
        wait_empty(60);
        toggle_en = 1'b0;

        // Reset with two entries pending.
        vrf_wvalid_i = 1'b0;
        push_word(1'b1, 10'h100, 64'hBEEF_0001, 1'b0, 3'd6);
        push_word(1'b1, 10'h101, 64'hBEEF_0002, 1'b1, 3'd6);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_we", 128'(vrf_we_o), 128'd0);
        chk("async_rst_rsp_valid", 128'(vfu_rsp_valid_o), 128'd0);
        chk("async_rst_empty", 128'(empty_o), 128'd1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        vrf_wvalid_i = 1'b1;
        repeat (5) step();
        chk("post_rst_empty", 128'(empty_o), 128'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
